shifter_share_arbiter: RTL and testbench
========================================

Name: shifter_share_arbiter

Overview:
- Shares one 16-bit barrel shifter datapath between two requesters, e.g. the execute-stage ALU and the address/immediate formatting path.
- Arbitrates round-robin, issues the winning operation to the internal shifter instance, and registers the result into a one-entry output buffer.
- Output buffer uses a valid/ready handshake toward the consumer.

Parameters:
- OPERAND_WIDTH, 16, data width of operands and result.
- SHAMT_WIDTH, 4, shift-amount width; must equal log2(OPERAND_WIDTH).
- NUM_OPERATIONS, 2, width of the operation select.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_in  in  OPERAND_WIDTH  requester 0 operand.
- req0_shamt  in  SHAMT_WIDTH  requester 0 shift amount.
- req0_oper  in  NUM_OPERATIONS  requester 0 operation.
- req1_valid, req1_ready, req1_in, req1_shamt, req1_oper: same as requester 0, for requester 1.
- rsp_valid  out  1  output buffer holds a result.
- rsp_ready  in  1  consumer takes the result this cycle.
- rsp_data  out  OPERAND_WIDTH  shifted result.
- rsp_id  out  1  requester that produced rsp_data.
- busy  out  1  output buffer occupied and not draining this cycle.

Behaviour:
- Oper encoding:
  - 00 rotate left.
  - 01 shift left logical, zero fill.
  - 10 rotate right.
  - 11 shift right logical, zero fill.
- ShAmt is 0..15. ShAmt 0 passes In unchanged for all operations.
- Reset (rst_n low, asynchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Priority pointer = requester 0.
  - busy=0, both req*_ready=0 while rst_n is low.
- can_accept = !rsp_valid || rsp_ready. This is combinational and permits full-throughput back-to-back operation.
- Grant (combinational, same cycle):
  - If can_accept and only one requester is valid, grant it.
  - If both are valid, grant the one the priority pointer names.
  - req_x_ready = grant_x. At most one ready per cycle; never ready without valid.
- Accept: on a rising edge with any grant, do all of the following.
  - rsp_data <= shifter(granted in, shamt, oper).
  - rsp_id <= granted index.
  - rsp_valid <= 1.
  - Priority pointer <= the non-granted requester.
- Latency: exactly 1 cycle from the accept edge to rsp_valid high.
- Pointer behaviour: it does not change on cycles without a grant. A lone requester still flips it, so the other requester wins the next contention.
- Drain: rsp_valid && rsp_ready with no new grant gives rsp_valid <= 0. rsp_data/rsp_id hold their last values.
- Stall: while rsp_valid && !rsp_ready:
  - rsp_data, rsp_id and rsp_valid hold stable.
  - Both ready outputs are 0.
  - Requesters hold valid and payload; the payload may not change until accepted.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and rsp_valid stays 1.
- busy = rsp_valid && !rsp_ready.
- Reset mid-operation: a buffered result is discarded and no response is emitted for it. Requesters must re-issue.
- Inputs must not be X when valid is high. Payload is ignored when valid is low.

Optional Feature:
- Macro: SHIFTER_ARB_STATS_EN.
- When defined, adds these outputs:
  - grant0_cnt[15:0] and grant1_cnt[15:0]: saturating counts of accepts per requester.
  - stall_cnt[15:0]: saturating count of cycles with rsp_valid && !rsp_ready.
  - Input stats_clr, synchronous; it zeroes all three counters and takes priority over increment in the same cycle.
  - All counters reset to 0 on rst_n.
- When undefined, none of these ports or registers exist and the core behaviour is identical.

Test Plan:
- Single op: req0 in=0x8001, shamt=1, oper=00, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=0x0003, rsp_id=0.
- Contention: both valid every cycle, req0 oper=01 in=0x00FF shamt=4, req1 oper=11 in=0xF000 shamt=12, rsp_ready=1:
  - Grants alternate 0,1,0,1.
  - Results alternate 0x0FF0 and 0x000F, with rsp_valid high every cycle.
- Backpressure: rsp_ready=0 for 5 cycles after a result 0x1234 (rotate right, shamt 0):
  - rsp_data stays 0x1234, both ready=0, busy=1.
  - On rsp_ready=1 the pending request is accepted in the same cycle.
- Boundaries: in=0xA5A5, shamt=15 for each oper -> 0xD2D2 (rotate left), 0x8000 (shift left), 0x4B4B (rotate right), 0x0001 (shift right logical).
- Async reset: assert rst_n low mid-stall with no clock edge -> rsp_valid=0 immediately; after release, first contention grants requester 0.
- SHIFTER_ARB_STATS_EN: 3 req0 accepts, 2 req1 accepts, 4 stall cycles -> counts 3/2/4; stats_clr for one cycle -> 0/0/0.

Source files
------------

// File: rtl/shifter_share_arbiter.sv
// Two requesters share one barrel shifter; round-robin grant feeds a one-entry valid/ready result buffer.
// Optional statistics counters are compiled in with `define SHIFTER_ARB_STATS_EN.

module shifter_share_arbiter_shift #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic [OPERAND_WIDTH-1:0]  operand,
    input  logic [SHAMT_WIDTH-1:0]    shamt,
    input  logic [NUM_OPERATIONS-1:0] oper,
    output logic [OPERAND_WIDTH-1:0]  result
);
    localparam logic [SHAMT_WIDTH:0] WIDTH_L = (SHAMT_WIDTH+1)'(OPERAND_WIDTH);

    logic [SHAMT_WIDTH:0]      inv;
    logic [OPERAND_WIDTH-1:0]  shl, shr, rol, ror;

    // inv reaches OPERAND_WIDTH at shamt 0, which shifts to zero and leaves the rotate a pass-through
    always_comb begin
        inv = WIDTH_L - {1'b0, shamt};
        shl = operand << shamt;
        shr = operand >> shamt;
        rol = shl | (operand >> inv);
        ror = shr | (operand << inv);
        case (oper)
            NUM_OPERATIONS'(0): result = rol;
            NUM_OPERATIONS'(1): result = shl;
            NUM_OPERATIONS'(2): result = ror;
            default:            result = shr;
        endcase
    end
endmodule

module shifter_share_arbiter #(
    parameter int OPERAND_WIDTH  = 16,
    parameter int SHAMT_WIDTH    = 4,
    parameter int NUM_OPERATIONS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [OPERAND_WIDTH-1:0]  req0_in,
    input  logic [SHAMT_WIDTH-1:0]    req0_shamt,
    input  logic [NUM_OPERATIONS-1:0] req0_oper,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [OPERAND_WIDTH-1:0]  req1_in,
    input  logic [SHAMT_WIDTH-1:0]    req1_shamt,
    input  logic [NUM_OPERATIONS-1:0] req1_oper,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [OPERAND_WIDTH-1:0]  rsp_data,
    output logic                      rsp_id,
    output logic                      busy
`ifdef SHIFTER_ARB_STATS_EN
    ,
    input  logic                      stats_clr,
    output logic [15:0]               grant0_cnt,
    output logic [15:0]               grant1_cnt,
    output logic [15:0]               stall_cnt
`endif
);
    typedef struct packed {
        logic [OPERAND_WIDTH-1:0]  operand;
        logic [SHAMT_WIDTH-1:0]    shamt;
        logic [NUM_OPERATIONS-1:0] oper;
    } op_t;

    op_t                      sel;
    logic                     can_accept, grant0, grant1, any_grant;
    logic                     ptr;  // 0: requester 0 wins contention, 1: requester 1
    logic [OPERAND_WIDTH-1:0] shift_result;

    assign can_accept = !rsp_valid || rsp_ready;
    // rst_n gating keeps both readies low throughout reset
    assign grant0     = rst_n && can_accept && req0_valid && (!req1_valid || !ptr);
    assign grant1     = rst_n && can_accept && req1_valid && (!req0_valid ||  ptr);
    assign any_grant  = grant0 || grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = rsp_valid && !rsp_ready;

    assign sel = grant1 ? op_t'{req1_in, req1_shamt, req1_oper}
                        : op_t'{req0_in, req0_shamt, req0_oper};

    shifter_share_arbiter_shift #(
        .OPERAND_WIDTH (OPERAND_WIDTH),
        .SHAMT_WIDTH   (SHAMT_WIDTH),
        .NUM_OPERATIONS(NUM_OPERATIONS)
    ) u_shift (
        .operand(sel.operand),
        .shamt  (sel.shamt),
        .oper   (sel.oper),
        .result (shift_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= 1'b0;
            ptr       <= 1'b0;
        end else if (any_grant) begin
            rsp_valid <= 1'b1;
            rsp_data  <= shift_result;
            rsp_id    <= grant1;
            ptr       <= grant0;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

`ifdef SHIFTER_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            stall_cnt  <= '0;
        end else if (stats_clr) begin
            grant0_cnt <= '0;
            grant1_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (grant0 && grant0_cnt != 16'hFFFF) grant0_cnt <= grant0_cnt + 16'd1;
            if (grant1 && grant1_cnt != 16'hFFFF) grant1_cnt <= grant1_cnt + 16'd1;
            if (busy   && stall_cnt  != 16'hFFFF) stall_cnt  <= stall_cnt  + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_shifter_share_arbiter.sv
// Directed bench for shifter_share_arbiter: single ops, contention, shift boundaries, backpressure, async reset.
module tb_shifter_share_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [15:0] req0_in, req1_in;
    logic [3:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_oper, req1_oper;
    logic        rsp_valid, rsp_ready, rsp_id, busy;
    logic [15:0] rsp_data;
`ifdef SHIFTER_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] grant0_cnt, grant1_cnt, stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    shifter_share_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in),
        .req0_shamt(req0_shamt), .req0_oper(req0_oper),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in),
        .req1_shamt(req1_shamt), .req1_oper(req1_oper),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .busy(busy)
`ifdef SHIFTER_ARB_STATS_EN
        , .stats_clr(stats_clr), .grant0_cnt(grant0_cnt),
        .grant1_cnt(grant1_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        req0_valid = v; req0_in = d; req0_shamt = s; req0_oper = o;
    endtask

    task automatic set1(input logic v, input logic [15:0] d, input logic [3:0] s, input logic [1:0] o);
        req1_valid = v; req1_in = d; req1_shamt = s; req1_oper = o;
    endtask

    // one lone request from requester 0, checked through the accept edge
    task automatic single0(input string tag, input logic [15:0] d, input logic [3:0] s,
                           input logic [1:0] o, input logic [15:0] exp);
        set0(1'b1, d, s, o);
        #1 chk({tag, "_ready"}, req0_ready, 1'b1);
        tick();
        set0(1'b0, 16'h0, 4'h0, 2'h0);
        chk({tag, "_valid"}, rsp_valid, 1'b1);
        chk({tag, "_data"}, rsp_data, exp);
        chk({tag, "_id"}, rsp_id, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; rsp_ready = 1'b1;
        set0(1'b1, 16'hFFFF, 4'h1, 2'h0);
        set1(1'b0, 16'h0, 4'h0, 2'h0);
`ifdef SHIFTER_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        #3;
        chk("rst_ready0", req0_ready, 1'b0);
        chk("rst_valid", rsp_valid, 1'b0);
        chk("rst_data", rsp_data, 16'h0);
        chk("rst_id", rsp_id, 1'b0);
        chk("rst_busy", busy, 1'b0);
        tick(); tick();
        set0(1'b0, 16'h0, 4'h0, 2'h0);
        rst_n = 1'b1;
        tick();

        // single op; ptr flips to requester 1
        single0("single", 16'h8001, 4'd1, 2'b00, 16'h0003);

        // lone requester 1 op returns the pointer to requester 0
        set1(1'b1, 16'hA5A5, 4'd15, 2'b00);
        #1 chk("lone1_ready1", req1_ready, 1'b1);
        chk("lone1_ready0", req0_ready, 1'b0);
        tick();
        set1(1'b0, 16'h0, 4'h0, 2'h0);
        chk("bnd_rol_data", rsp_data, 16'hD2D2);
        chk("bnd_rol_id", rsp_id, 1'b1);

        // contention: grants alternate 0,1,0,1
        set0(1'b1, 16'h00FF, 4'd4, 2'b01);
        set1(1'b1, 16'hF000, 4'd12, 2'b11);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready0", req0_ready, (i % 2) == 0);
            chk("cont_ready1", req1_ready, (i % 2) == 1);
            tick();
            chk("cont_valid", rsp_valid, 1'b1);
            chk("cont_id", rsp_id, i % 2);
            chk("cont_data", rsp_data, (i % 2) ? 16'h000F : 16'h0FF0);
        end
        set0(1'b0, 16'h0, 4'h0, 2'h0);
        set1(1'b0, 16'h0, 4'h0, 2'h0);

        // remaining shamt=15 boundaries
        single0("bnd_shl", 16'hA5A5, 4'd15, 2'b01, 16'h8000);
        single0("bnd_ror", 16'hA5A5, 4'd15, 2'b10, 16'h4B4B);
        single0("bnd_shr", 16'hA5A5, 4'd15, 2'b11, 16'h0001);
        tick();
        chk("drain_valid", rsp_valid, 1'b0);
        chk("drain_hold", rsp_data, 16'h0001);

        // backpressure: rotate right by 0 passes 0x1234 through, then 5 stalled cycles
        rsp_ready = 1'b0;
        single0("bp_first", 16'h1234, 4'd0, 2'b10, 16'h1234);
        set1(1'b1, 16'h0001, 4'd1, 2'b01);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready0", req0_ready, 1'b0);
            chk("bp_ready1", req1_ready, 1'b0);
            chk("bp_busy", busy, 1'b1);
            chk("bp_data", rsp_data, 16'h1234);
            chk("bp_valid", rsp_valid, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready1", req1_ready, 1'b1);
        chk("bp_release_busy", busy, 1'b0);
        tick();
        set1(1'b0, 16'h0, 4'h0, 2'h0);
        chk("bp_next_valid", rsp_valid, 1'b1);
        chk("bp_next_data", rsp_data, 16'h0002);
        chk("bp_next_id", rsp_id, 1'b1);

        // accept phase (3 req0, 2 req1) then a 4-cycle stall; pointer ends on requester 1
`ifdef SHIFTER_ARB_STATS_EN
        stats_clr = 1'b1;
`endif
        tick();
`ifdef SHIFTER_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        set0(1'b1, 16'h0001, 4'd1, 2'b01);
        set1(1'b1, 16'h0001, 4'd2, 2'b01);
        tick(); tick(); tick(); tick();
        set1(1'b0, 16'h0, 4'h0, 2'h0);
        tick();
        set0(1'b0, 16'h0, 4'h0, 2'h0);
        chk("acc_last_data", rsp_data, 16'h0002);
        chk("acc_last_id", rsp_id, 1'b0);
        rsp_ready = 1'b0;
        tick(); tick(); tick(); tick();
        chk("stall_busy", busy, 1'b1);
`ifdef SHIFTER_ARB_STATS_EN
        chk("stats_g0", grant0_cnt, 16'd3);
        chk("stats_g1", grant1_cnt, 16'd2);
        chk("stats_stall", stall_cnt, 16'd4);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_clr_g0", grant0_cnt, 16'd0);
        chk("stats_clr_g1", grant1_cnt, 16'd0);
        chk("stats_clr_stall", stall_cnt, 16'd0);
`endif

        // async reset mid-stall, away from any clock edge
        #1 rst_n = 1'b0;
        set0(1'b1, 16'h00FF, 4'd4, 2'b01);
        set1(1'b1, 16'hF000, 4'd12, 2'b11);
        #1;
        chk("arst_valid", rsp_valid, 1'b0);
        chk("arst_data", rsp_data, 16'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready0", req0_ready, 1'b0);
        chk("arst_ready1", req1_ready, 1'b0);
        rsp_ready = 1'b1;
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_ready0", req0_ready, 1'b1);
        chk("post_rst_ready1", req1_ready, 1'b0);
        tick();
        set0(1'b0, 16'h0, 4'h0, 2'h0);
        set1(1'b0, 16'h0, 4'h0, 2'h0);
        chk("post_rst_id", rsp_id, 1'b0);
        chk("post_rst_data", rsp_data, 16'h0FF0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
